// File: rtl/blake2_pkg.sv
// Shared BLAKE2 constants: FSM states, IV tables, G rotation amounts
// and the message permutation (sigma) rows.
package blake2_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Word 0 sits at the low end of each packed table.
    localparam logic [7:0][31:0] IV32 = {
        32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
        32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667
    };

    localparam logic [7:0][63:0] IV64 = {
        64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
        64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
        64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
        64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908
    };

    // IV word i for the given word width, zero-extended to 64 bits.
    function automatic logic [63:0] iv_word(input int w, input logic [2:0] i);
        if (w == 64) return IV64[i];
        return {32'h0, IV32[i]};
    endfunction

    // Right-rotation amount k (1..4) of the G function.
    function automatic int rot_amt(input int w, input int k);
        if (w == 64) begin
            case (k)
                1: return 32;
                2: return 24;
                3: return 16;
                default: return 63;
            endcase
        end
        case (k)
            1: return 16;
            2: return 12;
            3: return 8;
            default: return 7;
        endcase
    endfunction

    // Sigma row r; permutation entry k lives in nibble [63-4k -: 4].
    function automatic logic [63:0] sigma_row(input logic [3:0] r);
        case (r)
            4'd1: return 64'hEA489FD61C02B753;
            4'd2: return 64'hB8C052FDAE367194;
            4'd3: return 64'h7931DCBE265A40F8;
            4'd4: return 64'h905724AFE1BC683D;
            4'd5: return 64'h2C6A0B834D75FE19;
            4'd6: return 64'hC51FED4A0763928B;
            4'd7: return 64'hDB7EC13950F4862A;
            4'd8: return 64'h6FE9B308C2D714A5;
            4'd9: return 64'hA2847615FB9E3CD0;
            default: return 64'h0123456789ABCDEF;
        endcase
    endfunction

endpackage

// File: rtl/blake2_g.sv
// Combinational BLAKE2 G mixing function on four words plus two message words.
import blake2_pkg::*;

module blake2_g #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] a_new,
    output logic [W-1:0] b_new,
    output logic [W-1:0] c_new,
    output logic [W-1:0] d_new
);

    localparam int R1 = rot_amt(W, 1);
    localparam int R2 = rot_amt(W, 2);
    localparam int R3 = rot_amt(W, 3);
    localparam int R4 = rot_amt(W, 4);

    function automatic logic [W-1:0] ror(input logic [W-1:0] v, input int r);
        return (v >> r) | (v << (W - r));
    endfunction

    logic [W-1:0] a1, b1, c1, d1;

    // First half uses x, second half y; all adds wrap at W bits.
    assign a1    = a + b + x;
    assign d1    = ror(d ^ a1, R1);
    assign c1    = c + d1;
    assign b1    = ror(b ^ c1, R2);
    assign a_new = a1 + b1 + y;
    assign d_new = ror(d1 ^ a_new, R3);
    assign c_new = c1 + d_new;
    assign b_new = ror(b1 ^ c_new, R4);

endmodule

// File: rtl/f_sched.sv
// Per-step operand scheduler: picks the four v indices (column steps 0..3,
// diagonal steps 4..7) and the two message-word indices for a G step.
import blake2_pkg::*;

module f_sched (
    input  logic [2:0] sub_ctr,
    input  logic [3:0] rnd_ctr,
    output logic [3:0] a_sel,
    output logic [3:0] b_sel,
    output logic [3:0] c_sel,
    output logic [3:0] d_sel,
    output logic [3:0] m0_sel,
    output logic [3:0] m1_sel
);

    logic [63:0] row;
    logic [5:0]  sh0;
    logic [5:0]  sh1;
    logic [1:0]  j;
    logic        diag;

    // Diagonal steps skew b/c/d by 1/2/3 lanes; the 2-bit lane add wraps.
    always_comb begin
        j      = sub_ctr[1:0];
        diag   = sub_ctr[2];
        row    = sigma_row(rnd_ctr);
        sh0    = 6'd60 - {sub_ctr, 3'b000};
        sh1    = sh0 - 6'd4;
        a_sel  = {2'b00, j};
        b_sel  = {2'b01, j + {1'b0, diag}};
        c_sel  = {2'b10, j + {diag, 1'b0}};
        d_sel  = {2'b11, j + {diag, diag}};
        m0_sel = row[sh0 +: 4];
        m1_sel = row[sh1 +: 4];
    end

endmodule

// File: rtl/f_comp.sv
// BLAKE2 compression engine: one G step per clock over the 16-word working
// vector, 8 steps per round, then the chain-value feed-forward in FIN.
import blake2_pkg::*;

module f_comp #(
    parameter int W      = 32,
    parameter int ROUNDS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [8*W-1:0]  h_in,
    input  logic [16*W-1:0] m_in,
    input  logic [2*W-1:0]  t_in,
    input  logic            last_in,
    output logic            busy,
    output logic            done,
    output logic [8*W-1:0]  h_out
);

    state_t               state;
    logic [2:0]           sub;
    logic [3:0]           rnd;
    logic [3:0]           rnd_sched;
    logic [15:0][W-1:0]   v;
    logic [15:0][W-1:0]   m_r;
    logic [7:0][W-1:0]    h_r;
    logic [15:0][W-1:0]   v_init;
    logic [7:0][W-1:0]    iv_c;

    logic [3:0]   a_sel, b_sel, c_sel, d_sel, m0_sel, m1_sel;
    logic [W-1:0] g_a, g_b, g_c, g_d;

    for (genvar i = 0; i < 8; i++) begin : g_iv
        assign iv_c[i] = W'(iv_word(W, 3'(i)));
    end

    // Rounds 10 and 11 reuse sigma rows 0 and 1.
    assign rnd_sched = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;

    f_sched u_sched (
        .sub_ctr (sub),
        .rnd_ctr (rnd_sched),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .c_sel   (c_sel),
        .d_sel   (d_sel),
        .m0_sel  (m0_sel),
        .m1_sel  (m1_sel)
    );

    blake2_g #(.W(W)) u_g (
        .a     (v[a_sel]),
        .b     (v[b_sel]),
        .c     (v[c_sel]),
        .d     (v[d_sel]),
        .x     (m_r[m0_sel]),
        .y     (m_r[m1_sel]),
        .a_new (g_a),
        .b_new (g_b),
        .c_new (g_c),
        .d_new (g_d)
    );

    // Initial working vector: chain value, IV, counter and final-block flag folded in.
    always_comb begin
        v_init       = '0;
        v_init[7:0]  = h_in;
        v_init[15:8] = iv_c;
        v_init[12]   = v_init[12] ^ t_in[W-1:0];
        v_init[13]   = v_init[13] ^ t_in[2*W-1:W];
        if (last_in) v_init[14] = ~v_init[14];
    end

    // Control FSM, step counters, working vector and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            h_out <= '0;
            sub   <= '0;
            rnd   <= '0;
            v     <= '0;
            m_r   <= '0;
            h_r   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        h_r   <= h_in;
                        m_r   <= m_in;
                        v     <= v_init;
                        sub   <= '0;
                        rnd   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    v[a_sel] <= g_a;
                    v[b_sel] <= g_b;
                    v[c_sel] <= g_c;
                    v[d_sel] <= g_d;
                    sub      <= sub + 3'd1;
                    if (sub == 3'd7) begin
                        if (rnd == 4'(ROUNDS - 1)) begin
                            rnd   <= '0;
                            state <= FIN;
                        end else begin
                            rnd <= rnd + 4'd1;
                        end
                    end
                end
                FIN: begin
                    for (int i = 0; i < 8; i++)
                        h_out[i*W +: W] <= h_r[i] ^ v[i] ^ v[i+8];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f_comp.sv
// Directed bench for f_comp: BLAKE2s and BLAKE2b instances, scoreboard of
// expected chain values popped on each done pulse.
module tb_f_comp;

    localparam logic [255:0] EXP_S =
        256'h82596786_4C9B994D_293AD69E_208B4537_2F45EB4E_A32BA7E1_E2147C32_8C5E8C50;
    localparam logic [511:0] EXP_B = {
        64'h239900D4ED8623B9, 64'h5A92F1DBA88AD318,
        64'h95CC3345DED552C2, 64'h2D79AB2A39C5877D,
        64'hD1A2FFDB6FBB124B, 64'hB7C45A68142F214C,
        64'hE9F6129FB697276A, 64'h0D4D1C983FA580BA};
    localparam logic [255:0] IVS = {
        32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
        32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
    localparam logic [511:0] IVB = {
        64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B,
        64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
        64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B,
        64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908};

    logic         clk, rst;
    logic         start_s, last_s, busy_s, done_s;
    logic [255:0] h_in_s, h_out_s;
    logic [511:0] m_in_s;
    logic [63:0]  t_in_s;
    logic         start_b, last_b, busy_b, done_b;
    logic [511:0] h_in_b, h_out_b;
    logic [1023:0] m_in_b;
    logic [127:0] t_in_b;

    int checks = 0;
    int errors = 0;
    logic [511:0] sb_s[$];
    logic [511:0] sb_b[$];

    f_comp #(.W(32), .ROUNDS(10)) u_s (
        .clk(clk), .rst(rst), .start(start_s), .h_in(h_in_s), .m_in(m_in_s),
        .t_in(t_in_s), .last_in(last_s), .busy(busy_s), .done(done_s), .h_out(h_out_s));

    f_comp #(.W(64), .ROUNDS(12)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .h_in(h_in_b), .m_in(m_in_b),
        .t_in(t_in_b), .last_in(last_b), .busy(busy_b), .done(done_b), .h_out(h_out_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic abc_s();
        h_in_s = IVS ^ 256'h01010020;
        m_in_s = 512'h00636261;
        t_in_s = 64'd3;
        last_s = 1'b1;
    endtask

    task automatic abc_b();
        h_in_b = IVB ^ 512'h01010040;
        m_in_b = 1024'h636261;
        t_in_b = 128'd3;
        last_b = 1'b1;
    endtask

    task automatic scramble_s();
        for (int i = 0; i < 8; i++) h_in_s[i*32 +: 32] = $urandom;
        for (int i = 0; i < 16; i++) m_in_s[i*32 +: 32] = $urandom;
        t_in_s = {$urandom, $urandom};
        last_s = 1'b0;
    endtask

    task automatic scramble_b();
        for (int i = 0; i < 8; i++) h_in_b[i*64 +: 64] = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) m_in_b[i*64 +: 64] = {$urandom, $urandom};
        t_in_b = {$urandom, $urandom, $urandom, $urandom};
        last_b = 1'b0;
    endtask

    task automatic wait_s(output int n, output logic ok);
        n = 0;
        ok = 1'b1;
        while (done_s !== 1'b1 && n < 300) begin
            if (busy_s !== 1'b1) ok = 1'b0;
            step();
            n++;
        end
    endtask

    task automatic wait_b(output int n, output logic ok);
        n = 0;
        ok = 1'b1;
        while (done_b !== 1'b1 && n < 300) begin
            if (busy_b !== 1'b1) ok = 1'b0;
            step();
            n++;
        end
    endtask

    task automatic pop_s(input string tag);
        chk({tag, "_sb"}, 512'(sb_s.size() != 0), 512'd1);
        if (sb_s.size() != 0) chk(tag, 512'(h_out_s), sb_s.pop_front());
    endtask

    task automatic pop_b(input string tag);
        chk({tag, "_sb"}, 512'(sb_b.size() != 0), 512'd1);
        if (sb_b.size() != 0) chk(tag, h_out_b, sb_b.pop_front());
    endtask

    initial begin
        int   n;
        int   extra;
        logic ok;

        rst = 1'b1;
        start_s = 1'b0; start_b = 1'b0;
        scramble_s();
        scramble_b();
        repeat (3) step();
        chk("rst_busy_s", 512'(busy_s), 512'd0);
        chk("rst_done_s", 512'(done_s), 512'd0);
        chk("rst_hout_s", 512'(h_out_s), 512'd0);
        chk("rst_busy_b", 512'(busy_b), 512'd0);
        chk("rst_done_b", 512'(done_b), 512'd0);
        chk("rst_hout_b", h_out_b, 512'd0);
        rst = 1'b0;
        step();

        // Single BLAKE2s "abc" block with latency measurement
        abc_s();
        start_s = 1'b1;
        sb_s.push_back(512'(EXP_S));
        step();
        start_s = 1'b0;
        scramble_s();
        wait_s(n, ok);
        chk("lat_s", 512'(n), 512'd81);
        chk("busy_run_s", 512'(ok), 512'd1);
        chk("busy_at_done_s", 512'(busy_s), 512'd0);
        pop_s("abc_s");
        step();
        chk("done_pulse_s", 512'(done_s), 512'd0);
        chk("hold_s", 512'(h_out_s), 512'(EXP_S));

        // Start pulse while busy is ignored
        abc_s();
        start_s = 1'b1;
        sb_s.push_back(512'(EXP_S));
        step();
        start_s = 1'b0;
        repeat (19) step();
        scramble_s();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        wait_s(n, ok);
        chk("lat_perturb_s", 512'(n), 512'd61);
        pop_s("perturb_s");
        extra = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (done_s === 1'b1 || busy_s === 1'b1) extra++;
        end
        chk("no_extra_done_s", 512'(extra), 512'd0);

        // Reset mid-run aborts immediately
        abc_s();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        repeat (40) step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 512'(busy_s), 512'd0);
        chk("midrst_done", 512'(done_s), 512'd0);
        chk("midrst_hout", 512'(h_out_s), 512'd0);
        step();
        rst = 1'b0;
        step();
        abc_s();
        start_s = 1'b1;
        sb_s.push_back(512'(EXP_S));
        step();
        start_s = 1'b0;
        scramble_s();
        wait_s(n, ok);
        chk("lat_after_rst", 512'(n), 512'd81);
        pop_s("abc_after_rst");

        // Back-to-back blocks with start held high
        step();
        abc_s();
        start_s = 1'b1;
        sb_s.push_back(512'(EXP_S));
        sb_s.push_back(512'(EXP_S));
        step();
        wait_s(n, ok);
        chk("b2b_lat1", 512'(n), 512'd81);
        pop_s("b2b_first");
        step();
        start_s = 1'b0;
        chk("b2b_accept", 512'(busy_s), 512'd1);
        chk("b2b_done_low", 512'(done_s), 512'd0);
        wait_s(n, ok);
        chk("b2b_gap", 512'(n + 1), 512'd82);
        chk("b2b_busy_run", 512'(ok), 512'd1);
        pop_s("b2b_second");

        // BLAKE2b "abc" block
        abc_b();
        start_b = 1'b1;
        sb_b.push_back(EXP_B);
        step();
        start_b = 1'b0;
        scramble_b();
        wait_b(n, ok);
        chk("lat_b", 512'(n), 512'd97);
        chk("busy_run_b", 512'(ok), 512'd1);
        chk("busy_at_done_b", 512'(busy_b), 512'd0);
        pop_b("abc_b");
        step();
        chk("done_pulse_b", 512'(done_b), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
